// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request, IF/ID output register plus 1-entry skid buffer.
// Latency: 1 cycle from an accepted imem transfer to instr_valid (EMPTY -> FULL).
// Backpressure: stall holds the output; one extra word lands in the skid, then imem_re drops.
// Optional macro FETCH_PERF_EN adds saturating fetch_cnt / bubble_cnt outputs.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_re,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [15:0] i_addr,
    output logic        instr_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] out_dat;
    logic [15:0] out_addr;
    logic [15:0] skid_dat;
    logic [15:0] skid_addr;
    logic        xfer;
    logic        load_out_mem;
    logic        load_out_skid;
    logic        load_skid;

    // Request whenever there is room for one more word; never while in reset.
    assign imem_re     = !rst && (state != SKID);
    assign xfer        = imem_re && imem_rdy;
    assign imem_addr   = pc;
    assign instr_valid = (state != EMPTY);
    // Present a no-op encoding whenever nothing real is held.
    assign instr       = instr_valid ? out_dat : 16'h0000;
    assign i_addr      = out_addr;

    // Occupancy next-state and register load selects; redirect flushes everything.
    always_comb begin
        state_nxt     = state;
        load_out_mem  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (redirect) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        load_out_mem = 1'b1;
                        state_nxt    = FULL;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        if (xfer) begin
                            load_out_mem = 1'b1;
                        end else begin
                            state_nxt = EMPTY;
                        end
                    end else if (xfer) begin
                        load_skid = 1'b1;
                        state_nxt = SKID;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        load_out_skid = 1'b1;
                        state_nxt     = FULL;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // PC: reload on redirect, otherwise advance (wrapping) on each accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (xfer) begin
            pc <= pc + 16'd1;
        end
    end

    // Output and skid data/address registers; the address travels with its word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_dat   <= 16'h0000;
            out_addr  <= RESET_PC;
            skid_dat  <= 16'h0000;
            skid_addr <= 16'h0000;
        end else begin
            if (load_out_mem) begin
                out_dat  <= imem_data;
                out_addr <= pc;
            end else if (load_out_skid) begin
                out_dat  <= skid_dat;
                out_addr <= skid_addr;
            end
            if (load_skid) begin
                skid_dat  <= imem_data;
                skid_addr <= pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters: accepted (non-flushed) transfers and unstalled empty cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt  <= 16'h0000;
            bubble_cnt <= 16'h0000;
        end else begin
            if (xfer && !redirect && (fetch_cnt != 16'hFFFF)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (!instr_valid && !stall && (bubble_cnt != 16'hFFFF)) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue model (fetched words wait in order until consumed).
module tb_fetch_unit;

    localparam logic [15:0] RPC = 16'h0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_re;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [15:0] i_addr;
    logic        instr_valid;

    int checks = 0;
    int errors = 0;

    // Model: PC plus queue of {addr,data} fetched but not yet consumed by decode.
    logic [15:0] m_pc;
    logic [31:0] m_q[$];

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_re     (imem_re),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_data   (imem_data),
        .instr       (instr),
        .i_addr      (i_addr),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model for the current inputs.
    task automatic compare();
        chk("imem_re", 16'(imem_re), 16'((!rst && m_q.size() < 2) ? 1 : 0));
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 16'(instr_valid), 16'((m_q.size() > 0) ? 1 : 0));
        if (m_q.size() > 0) begin
            chk("instr", instr, m_q[0][15:0]);
            chk("i_addr", i_addr, m_q[0][31:16]);
        end else begin
            chk("instr_empty", instr, 16'h0000);
        end
    endtask

    // Model update for one clock edge, using the inputs that were just sampled.
    task automatic model_step();
        bit xfer;
        bit consume;
        if (rst) begin
            m_pc = RPC;
            m_q.delete();
        end else if (redirect) begin
            m_pc = redirect_pc;
            m_q.delete();
        end else begin
            xfer    = (m_q.size() < 2) && imem_rdy;
            consume = (m_q.size() > 0) && !stall;
            if (consume) void'(m_q.pop_front());
            if (xfer) begin
                m_q.push_back({m_pc, imem_data});
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    // One clock: drive inputs at negedge, compare, advance model at posedge, settle #1.
    task automatic cycle(input logic r, input logic st, input logic rd, input logic [15:0] rpc,
                         input logic rdy, input logic [15:0] d);
        @(negedge clk);
        rst = r; stall = st; redirect = rd; redirect_pc = rpc; imem_rdy = rdy; imem_data = d;
        #1;
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; imem_rdy = 1'b1; imem_data = 16'h0;
        m_pc = 16'hxxxx;
        @(posedge clk);
        model_step();
        #1;
        // Reset state
        cycle(1, 0, 0, 16'h0, 1, 16'h1111);
        chk("rst_imem_re", 16'(imem_re), 16'h0);
        chk("rst_addr", imem_addr, 16'h0010);
        chk("rst_valid", 16'(instr_valid), 16'h0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_iaddr", i_addr, 16'h0010);

        // Sequential fetch from RESET_PC
        cycle(0, 0, 0, 16'h0, 1, 16'hA000);
        chk("seq_addr1", imem_addr, 16'h0011);
        chk("seq_valid1", 16'(instr_valid), 16'h1);
        chk("seq_instr1", instr, 16'hA000);
        chk("seq_iaddr1", i_addr, 16'h0010);
        cycle(0, 0, 0, 16'h0, 1, 16'hA001);
        chk("seq_addr2", imem_addr, 16'h0012);
        chk("seq_iaddr2", i_addr, 16'h0011);

        // Stall 3 cycles: one word to skid, then imem_re low
        cycle(0, 1, 0, 16'h0, 1, 16'hA002);
        chk("stall_re1", 16'(imem_re), 16'h0);
        chk("stall_iaddr", i_addr, 16'h0011);
        cycle(0, 1, 0, 16'h0, 1, 16'hBAD0);
        chk("stall_re2", 16'(imem_re), 16'h0);
        cycle(0, 1, 0, 16'h0, 1, 16'hBAD1);
        chk("stall_addr", imem_addr, 16'h0013);
        cycle(0, 0, 0, 16'h0, 0, 16'hBAD2);
        chk("skid_iaddr", i_addr, 16'h0012);
        chk("skid_instr", instr, 16'hA002);
        cycle(0, 0, 0, 16'h0, 0, 16'hBAD3);
        chk("drain_valid", 16'(instr_valid), 16'h0);

        // imem_rdy low: address held, bubbles
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 16'h0, 0, 16'h5555);
            chk("wait_addr", imem_addr, 16'h0013);
            chk("wait_instr", instr, 16'h0000);
        end

        // Redirect with stall and a same-cycle transfer
        cycle(0, 0, 0, 16'h0, 1, 16'hB013);
        cycle(0, 1, 1, 16'h0200, 1, 16'hDEAD);
        chk("redir_valid", 16'(instr_valid), 16'h0);
        chk("redir_instr", instr, 16'h0000);
        chk("redir_addr", imem_addr, 16'h0200);
        cycle(0, 0, 0, 16'h0, 1, 16'hC200);
        chk("redir_iaddr", i_addr, 16'h0200);
        chk("redir_first", instr, 16'hC200);

        // PC wrap
        cycle(0, 0, 1, 16'hFFFF, 1, 16'hDEAD);
        cycle(0, 0, 0, 16'h0, 1, 16'hC0FF);
        chk("wrap_iaddr", i_addr, 16'hFFFF);
        chk("wrap_addr", imem_addr, 16'h0000);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            logic [15:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 19) == 0), rp,
                  ($urandom_range(0, 9) < 7), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock for all state, rising-edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  decode/hazard hold; IF/ID outputs held while high.
REQ-005 SHALL have port redirect  input  1  taken jump/branch; flushes the pipe and reloads the PC.
REQ-006 SHALL have port redirect_pc  input  16  new fetch address, sampled when redirect is high.
REQ-007 SHALL have port imem_re  output  1  instruction-memory read request, level.
REQ-008 SHALL have port imem_addr  output  16  word address of the request, always equal to the PC.
REQ-009 SHALL have port imem_rdy  input  1  memory ready; imem_re & imem_rdy in the same cycle is one transfer.
REQ-010 SHALL have port imem_data  input  16  instruction word, valid when imem_rdy is high.
REQ-011 SHALL have port instr  output  16  instruction to decode; 16'h0000 (ADD to r0, no write) whenever instr_valid is low.
REQ-012 SHALL have port i_addr  output  16  word address of instr.
REQ-013 SHALL have port instr_valid  output  1  instr/i_addr hold a real fetched instruction.

Function
REQ-014 SHALL track occupancy with FSM states EMPTY (no output), FULL (output register valid) and SKID (output and 1-entry skid buffer valid).
REQ-015 SHALL assert imem_re in EMPTY and FULL, and deassert it in SKID.
REQ-016 SHALL hold imem_addr stable while imem_re is high and imem_rdy is low.
REQ-017 On a transfer, SHALL increment the PC by 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-018 In EMPTY, a transfer SHALL load the output register and move to FULL; instr_valid rises the next cycle (1-cycle fetch latency at imem_rdy=1).
REQ-019 In FULL with stall low, a transfer SHALL replace the output register; with no transfer, SHALL go to EMPTY.
REQ-020 In FULL with stall high, a transfer SHALL load the skid buffer and move to SKID; otherwise SHALL hold.
REQ-021 In SKID with stall low, SHALL move the skid buffer to the output register and go to FULL; with stall high, SHALL hold.
REQ-022 When redirect is high, SHALL set PC to redirect_pc, invalidate the output and skid registers, go to EMPTY, and discard any same-cycle transfer; redirect SHALL override stall.
REQ-023 SHALL present redirect_pc on imem_addr in the cycle after redirect.
REQ-024 SHALL never drop or duplicate an instruction while stall toggles in any pattern.
REQ-025 SHALL keep i_addr equal to the PC value at which the presented instr was fetched.

Reset
REQ-026 When rst is high at a clock edge, SHALL set PC=RESET_PC, state=EMPTY, instr=16'h0000, i_addr=RESET_PC, instr_valid=0, skid invalid; rst SHALL override redirect and stall.
REQ-027 While rst is high, imem_re SHALL be 0; any transfer in that cycle SHALL be ignored.

Configuration
REQ-028 SHALL compile, under macro FETCH_PERF_EN, outputs fetch_cnt[15:0] (number of transfers accepted) and bubble_cnt[15:0] (cycles with instr_valid low and stall low), both saturating at 16'hFFFF and cleared by rst.
REQ-029 Without FETCH_PERF_EN, SHALL omit those ports and counters, with all other behaviour identical.

Verification
REQ-030 Reset with RESET_PC=16'h0010, imem_rdy=1 -> imem_addr 0010,0011,0012 on successive cycles; instr_valid rises 1 cycle after the first transfer.
REQ-031 FULL, stall=1 for 3 cycles, imem_rdy=1 -> one word captured in skid, imem_re low for the 2 following cycles; after stall drops, instructions at 0x11 and 0x12 appear in order, none lost.
REQ-032 redirect=1, redirect_pc=16'h0200, simultaneous with stall=1 and a transfer -> next cycle instr_valid=0, instr=0000, imem_addr=0200; the transferred word never appears.
REQ-033 PC=16'hFFFF, transfer -> i_addr=FFFF, next imem_addr=0000.
REQ-034 imem_rdy low for 4 cycles -> imem_addr constant, instr_valid=0, instr=0000; with FETCH_PERF_EN, bubble_cnt increases by 4 and fetch_cnt is unchanged.
